// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one byte-enabled RAM port among NUM_REQ requesters,
// with optional grant lock for bursts and a fixed-latency response return path.
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BYTE_WIDTH  = 8,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ-1:0]                 req_lock_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata_i,
    input  logic [NUM_REQ*(DATA_WIDTH/BYTE_WIDTH)-1:0] req_wstrb_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic                               rsp_write_o,
    output logic [DATA_WIDTH-1:0]              rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0]              ram_addr_o,
    output logic [DATA_WIDTH-1:0]              ram_wdata_o,
    output logic [(DATA_WIDTH/BYTE_WIDTH)-1:0] ram_byte_en_o,
    input  logic [DATA_WIDTH-1:0]              ram_rdata_i
);

    localparam int unsigned STRB_W = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;

    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               accept;
    logic [STRB_W-1:0]  sel_strb;

    logic               pipe_vld [RAM_LATENCY];
    logic [IDX_W-1:0]   pipe_id  [RAM_LATENCY];
    logic               pipe_wr  [RAM_LATENCY];

    // Grant selection: locked owner only, else first valid after the rr pointer
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state == ST_LOCKED) begin
            grant_vld = req_valid_i[owner];
            grant_idx = owner;
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
                if (!grant_vld && req_valid_i[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign accept   = grant_vld && !rst_in;
    assign sel_strb = req_wstrb_i[grant_idx*STRB_W +: STRB_W];

    // RAM port is a direct mux of the winner; byte enables forced low when idle
    always_comb begin
        req_ready_o   = '0;
        ram_byte_en_o = '0;
        ram_addr_o    = req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata_o   = req_wdata_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        if (accept) begin
            req_ready_o   = NUM_REQ'(1) << grant_idx;
            ram_byte_en_o = sel_strb;
        end
    end

    // Arbitration state and response tracking shift register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= ST_ARB;
            rr_ptr <= IDX_W'(NUM_REQ - 1);
            owner  <= '0;
            for (int unsigned s = 0; s < RAM_LATENCY; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_id[s]  <= '0;
                pipe_wr[s]  <= 1'b0;
            end
        end else begin
            case (state)
                ST_ARB: begin
                    if (grant_vld) begin
                        rr_ptr <= grant_idx;
                        if (req_lock_i[grant_idx]) begin
                            state <= ST_LOCKED;
                            owner <= grant_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!req_lock_i[owner]) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase

            pipe_vld[0] <= accept;
            pipe_id[0]  <= grant_idx;
            pipe_wr[0]  <= |sel_strb;
            for (int unsigned s = 1; s < RAM_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
                pipe_wr[s]  <= pipe_wr[s-1];
            end
        end
    end

    // Response returns to the beat's owner exactly RAM_LATENCY cycles after accept
    always_comb begin
        rsp_valid_o = '0;
        if (pipe_vld[RAM_LATENCY-1] && !rst_in) begin
            rsp_valid_o = NUM_REQ'(1) << pipe_id[RAM_LATENCY-1];
        end
    end

    assign rsp_write_o = pipe_wr[RAM_LATENCY-1];
    assign rsp_rdata_o = ram_rdata_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a reference arbiter/memory model predicts
// grants and responses; a monitor process checks responses as the DUT presents them.
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int L  = 1;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_ready_o;
    logic [N-1:0]      req_lock_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N*SW-1:0]   req_wstrb_i;
    logic [N-1:0]      rsp_valid_o;
    logic              rsp_write_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic [AW-1:0]     ram_addr_o;
    logic [DW-1:0]     ram_wdata_o;
    logic [SW-1:0]     ram_byte_en_o;
    logic [DW-1:0]     ram_rdata_i;

    ram_port_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .RAM_LATENCY(L)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_lock_i(req_lock_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o), .rsp_rdata_o(rsp_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_byte_en_o(ram_byte_en_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_in = ~clk_in;

    // Applied stimulus (d_*) and staged next-cycle stimulus (n_*)
    logic [N-1:0]  d_valid = '0, d_lock = '0, n_valid = '0, n_lock = '0;
    logic [AW-1:0] d_addr [N], n_addr [N];
    logic [DW-1:0] d_wdata[N], n_wdata[N];
    logic [SW-1:0] d_strb [N], n_strb [N];

    always_comb begin
        req_valid_i = d_valid;
        req_lock_i  = d_lock;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW]  = d_addr[i];
            req_wdata_i[i*DW +: DW] = d_wdata[i];
            req_wstrb_i[i*SW +: SW] = d_strb[i];
        end
    end

    // Environment RAM: byte-enabled, read data L cycles after sampling
    logic [DW-1:0] ram [64] = '{default: '0};
    logic [DW-1:0] rd_pipe [L];
    always @(posedge clk_in) begin
        for (int b = 0; b < SW; b++)
            if (ram_byte_en_o[b]) ram[ram_addr_o[5:0]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        rd_pipe[0] <= ram[ram_addr_o[5:0]];
        for (int s = 1; s < L; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign ram_rdata_i = rd_pipe[L-1];

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Reference model
    typedef struct {
        int          id;
        bit          wr;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t        q[$];
    logic [31:0] ref_mem [64] = '{default: '0};
    int          m_rr = N - 1;
    bit          m_locked = 1'b0;
    int          m_owner = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply staged inputs, predict, check RAM-side outputs, update model
    task automatic step(input bit rst);
        int          g;
        logic [N-1:0] exp_ready;
        logic [31:0] cur;
        @(posedge clk_in);
        #1;
        rst_in  = rst;
        d_valid = n_valid;
        d_lock  = n_lock;
        for (int i = 0; i < N; i++) begin
            d_addr[i]  = n_addr[i];
            d_wdata[i] = n_wdata[i];
            d_strb[i]  = n_strb[i];
        end
        g = -1;
        if (rst) begin
            q.delete();
            m_rr     = N - 1;
            m_locked = 1'b0;
        end else if (m_locked) begin
            if (d_valid[m_owner]) g = m_owner;
        end else begin
            for (int k = 1; k <= N; k++)
                if (g < 0 && d_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;

        @(negedge clk_in);
        chk("ready", 64'(req_ready_o), 64'(exp_ready));
        chk("byte_en", 64'(ram_byte_en_o), (g >= 0) ? 64'(d_strb[g]) : 64'd0);
        if (g >= 0) begin
            chk("ram_addr", 64'(ram_addr_o), 64'(d_addr[g]));
            if (d_strb[g] != '0) chk("ram_wdata", 64'(ram_wdata_o), 64'(d_wdata[g]));
        end

        if (!rst) begin
            if (g >= 0) begin
                cur = ref_mem[d_addr[g][5:0]];
                for (int b = 0; b < SW; b++)
                    if (d_strb[g][b]) cur[b*8 +: 8] = d_wdata[g][b*8 +: 8];
                ref_mem[d_addr[g][5:0]] = cur;
                q.push_back('{id: g, wr: (d_strb[g] != '0), data: cur, due: cyc + L});
            end
            if (m_locked) begin
                if (!d_lock[m_owner]) m_locked = 1'b0;
            end else if (g >= 0) begin
                m_rr = g;
                if (d_lock[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end
        end
    endtask

    // Response monitor
    always @(negedge clk_in) begin
        logic [N-1:0] exp_v;
        exp_v = '0;
        if (q.size() > 0 && q[0].due == cyc) exp_v[q[0].id] = 1'b1;
        chk("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
        if (exp_v != '0) begin
            chk("rsp_write", 64'(rsp_write_o), 64'(q[0].wr));
            if (!q[0].wr) chk("rsp_rdata", 64'(rsp_rdata_o), 64'(q[0].data));
            void'(q.pop_front());
        end else if (q.size() > 0 && q[0].due < cyc) begin
            void'(q.pop_front());
        end
    end

    task automatic idle_inputs();
        n_valid = '0;
        n_lock  = '0;
        for (int i = 0; i < N; i++) begin
            n_addr[i]  = '0;
            n_wdata[i] = '0;
            n_strb[i]  = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input bit lk);
        n_valid[i] = 1'b1;
        n_lock[i]  = lk;
        n_addr[i]  = a;
        n_wdata[i] = d;
        n_strb[i]  = s;
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            d_addr[i] = '0; d_wdata[i] = '0; d_strb[i] = '0;
        end

        // Reset held with every requester valid
        for (int i = 0; i < N; i++) set_req(i, AW'(i), 32'h0, 4'h0, 1'b0);
        repeat (3) step(1'b1);

        // Round-robin with everyone valid, reads only
        for (int i = 0; i < N; i++) set_req(i, AW'(40 + i), 32'h0, 4'h0, 1'b0);
        repeat (8) step(1'b0);

        // Read latency: requester 2 writes then reads 0x10
        idle_inputs();
        set_req(2, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0);
        step(1'b0);
        idle_inputs();
        step(1'b0);
        set_req(2, 16'h0010, 32'h0, 4'h0, 1'b0);
        step(1'b0);
        idle_inputs();
        repeat (2) step(1'b0);

        // Partial write: requester 1 over 0xAAAAAAAA at 0x20, then read back
        set_req(1, 16'h0020, 32'hAAAAAAAA, 4'hF, 1'b0);
        step(1'b0);
        set_req(1, 16'h0020, 32'h11223344, 4'b0011, 1'b0);
        step(1'b0);
        set_req(1, 16'h0020, 32'h0, 4'h0, 1'b0);
        step(1'b0);
        idle_inputs();
        repeat (2) step(1'b0);

        // Locked burst by requester 0 with a two-cycle gap, others valid throughout
        step(1'b1);
        for (int i = 1; i < N; i++) set_req(i, AW'(50 + i), 32'h0, 4'h0, 1'b0);
        for (int b = 0; b < 6; b++) begin
            if (b == 2 || b == 3) begin
                n_valid[0] = 1'b0;
                n_lock[0]  = 1'b1;
            end else begin
                set_req(0, AW'(8 + b), 32'h5000_0000 + 32'(b), 4'hF, (b != 5));
            end
            step(1'b0);
        end
        n_valid[0] = 1'b0;
        n_lock[0]  = 1'b0;
        repeat (4) step(1'b0);

        // Reset while locked with a read in flight
        idle_inputs();
        step(1'b1);
        set_req(2, 16'h0010, 32'h0, 4'h0, 1'b1);
        step(1'b0);
        for (int i = 0; i < N; i++) set_req(i, AW'(i), 32'h0, 4'h0, 1'b0);
        step(1'b1);
        repeat (3) step(1'b0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                n_valid[i] = ($urandom_range(0, 9) < 7);
                n_lock[i]  = ($urandom_range(0, 9) < 3);
                n_addr[i]  = AW'($urandom_range(0, 63));
                n_wdata[i] = $urandom;
                n_strb[i]  = ($urandom_range(0, 1) == 0) ? 4'h0 : SW'($urandom);
            end
            step($urandom_range(0, 99) == 0);
        end

        idle_inputs();
        repeat (L + 3) step(1'b0);
        chk("drain", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
